// File: rtl/wl_pkg.sv
// Wakelet shared package: bus widths, reqrsp and AXI-Lite structs, the data-side
// memory map and the LSU bridge state encoding.
// The memory map constants are consumed by the bridge address check, which is
// compiled in only when WL_BRIDGE_ADDR_CHECK_EN is defined.
package wl_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;
   typedef logic [StrbWidth-1:0] strb_t;

   // Snitch atomic opcodes carried on the core data q channel
   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOLR   = 4'hA,
      AMOSC   = 4'hB
   } amo_op_e;

   // ---------------- core_data reqrsp ----------------
   typedef struct packed {
      addr_t      addr;
      logic       write;
      amo_op_e    amo;
      data_t      data;
      strb_t      strb;
      logic [1:0] size;
   } core_data_q_t;

   typedef struct packed {
      core_data_q_t q;
      logic         q_valid;
      logic         p_ready;
   } core_data_req_t;

   typedef struct packed {
      data_t data;
      logic  error;
   } core_data_p_t;

   typedef struct packed {
      core_data_p_t p;
      logic         p_valid;
      logic         q_ready;
   } core_data_rsp_t;

   // ---------------- AXI-Lite ----------------
   typedef struct packed {
      addr_t      addr;
      logic [2:0] prot;
   } axi_lite_ax_t;

   typedef struct packed {
      data_t data;
      strb_t strb;
   } axi_lite_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_lite_b_t;

   typedef struct packed {
      data_t      data;
      logic [1:0] resp;
   } axi_lite_r_t;

   typedef struct packed {
      axi_lite_ax_t aw;
      logic         aw_valid;
      axi_lite_w_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_lite_ax_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_lite_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      axi_lite_b_t b;
      logic        b_valid;
      logic        ar_ready;
      axi_lite_r_t r;
      logic        r_valid;
   } axi_lite_resp_t;

   // ---------------- memory map ----------------
   localparam addr_t BootromBaseAddr  = 32'h0000_0000;
   localparam addr_t BootromOffset    = 32'h0000_1000;
   localparam addr_t InstrMemBaseAddr = 32'h0001_0000;
   localparam addr_t InstrMemOffset   = 32'h0001_0000;
   localparam addr_t DataMemBaseAddr  = 32'h0002_0000;
   localparam addr_t DataMemOffset    = 32'h0001_0000;
   localparam addr_t CsrBaseAddr      = 32'h0004_0000;
   localparam addr_t CsrOffset        = 32'h0000_1000;
   localparam addr_t HwpeBaseAddr     = 32'h0005_0000;
   localparam addr_t HwpeOffset       = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] idx;
      addr_t       base;
      addr_t       mask;
   } addr_napot_demux_rule_t;

   // Regions are naturally aligned powers of two, so a mask selects the base bits
   function automatic addr_t napot_mask(input addr_t offset);
      return ~(offset - addr_t'(1));
   endfunction

   localparam int unsigned WlNumMapRules = 5;

   localparam addr_napot_demux_rule_t [WlNumMapRules-1:0] WlMemMap = '{
      '{idx: 32'd4, base: HwpeBaseAddr,     mask: napot_mask(HwpeOffset)},
      '{idx: 32'd3, base: CsrBaseAddr,      mask: napot_mask(CsrOffset)},
      '{idx: 32'd2, base: DataMemBaseAddr,  mask: napot_mask(DataMemOffset)},
      '{idx: 32'd1, base: InstrMemBaseAddr, mask: napot_mask(InstrMemOffset)},
      '{idx: 32'd0, base: BootromBaseAddr,  mask: napot_mask(BootromOffset)}
   };

   // LSU-to-AXI-Lite bridge control states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      WRITE_B  = 3'd2,
      READ     = 3'd3,
      READ_R   = 3'd4,
      ERR_RESP = 3'd5,
      RESP     = 3'd6
   } bridge_state_e;

endpackage

// File: rtl/wl_addr_napot_check.sv
// Combinational memory-map hit detector for the LSU bridge. Only built when
// WL_BRIDGE_ADDR_CHECK_EN is defined; the default build forwards every address.
`ifdef WL_BRIDGE_ADDR_CHECK_EN
module wl_addr_napot_check
   import wl_pkg::*;
(
   input  logic [AddrWidth-1:0] i_addr,
   output logic                 o_hit
);

   // Hit when the address falls inside any NAPOT region of the map
   always_comb begin
      o_hit = 1'b0;
      for (int unsigned i = 0; i < WlNumMapRules; i++) begin
         if ((i_addr & WlMemMap[i].mask) == WlMemMap[i].base) o_hit = 1'b1;
      end
   end

endmodule
`endif

// File: rtl/wl_reqrsp_axi_lite_bridge.sv
// Core LSU (reqrsp) to AXI-Lite bridge, one transaction in flight.
// Each q request becomes exactly one AXI-Lite read or write; AMOs are refused
// with an error response and never reach the fabric.
// Optional: WL_BRIDGE_ADDR_CHECK_EN rejects addresses outside the memory map
// locally instead of relying on the fabric's decode error.
module wl_reqrsp_axi_lite_bridge #(
   parameter int unsigned AddrWidth       = wl_pkg::AddrWidth,
   parameter int unsigned DataWidth       = wl_pkg::DataWidth,
   parameter type         core_data_req_t = wl_pkg::core_data_req_t,
   parameter type         core_data_rsp_t = wl_pkg::core_data_rsp_t,
   parameter type         axi_lite_req_t  = wl_pkg::axi_lite_req_t,
   parameter type         axi_lite_rsp_t  = wl_pkg::axi_lite_resp_t
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  core_data_req_t core_data_req_i,
   output core_data_rsp_t core_data_rsp_o,
   output axi_lite_req_t  axi_lite_req_o,
   input  axi_lite_rsp_t  axi_lite_rsp_i
);

   import wl_pkg::*;

   bridge_state_e          r_state;
   bridge_state_e          w_state_nxt;
   logic                   r_live;       // low for the first cycle out of reset
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_wdata;
   logic [DataWidth/8-1:0] r_strb;
   logic [DataWidth-1:0]   r_pdata;
   logic                   r_err;
   logic                   r_aw_sent;
   logic                   r_w_sent;

   logic w_q_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic w_aw_done, w_w_done;
   logic w_addr_hit;
   logic w_unused;

`ifdef WL_BRIDGE_ADDR_CHECK_EN
   wl_addr_napot_check u_addr_check (
      .i_addr (core_data_req_i.q.addr),
      .o_hit  (w_addr_hit)
   );
`else
   assign w_addr_hit = 1'b1;
`endif

   // Transfer size is the initiator's concern; low resp bit carries no error info
   assign w_unused = ^{core_data_req_i.q.size, axi_lite_rsp_i.b.resp[0],
                       axi_lite_rsp_i.r.resp[0]};

   // Drive both interfaces purely from state and captured registers
   always_comb begin
      core_data_rsp_o         = '0;
      core_data_rsp_o.q_ready = r_live && (r_state == IDLE);
      core_data_rsp_o.p_valid = (r_state == RESP);
      core_data_rsp_o.p.data  = r_pdata;
      core_data_rsp_o.p.error = r_err;

      axi_lite_req_o          = '0;
      axi_lite_req_o.aw.addr  = r_addr;
      axi_lite_req_o.aw.prot  = 3'b000;
      axi_lite_req_o.aw_valid = (r_state == WRITE) && !r_aw_sent;
      axi_lite_req_o.w.data   = r_wdata;
      axi_lite_req_o.w.strb   = r_strb;
      axi_lite_req_o.w_valid  = (r_state == WRITE) && !r_w_sent;
      axi_lite_req_o.b_ready  = (r_state == WRITE_B);
      axi_lite_req_o.ar.addr  = r_addr;
      axi_lite_req_o.ar.prot  = 3'b000;
      axi_lite_req_o.ar_valid = (r_state == READ);
      axi_lite_req_o.r_ready  = (r_state == READ_R);
   end

   assign w_q_hs  = core_data_rsp_o.q_ready && core_data_req_i.q_valid;
   assign w_aw_hs = axi_lite_req_o.aw_valid && axi_lite_rsp_i.aw_ready;
   assign w_w_hs  = axi_lite_req_o.w_valid  && axi_lite_rsp_i.w_ready;
   assign w_b_hs  = axi_lite_req_o.b_ready  && axi_lite_rsp_i.b_valid;
   assign w_ar_hs = axi_lite_req_o.ar_valid && axi_lite_rsp_i.ar_ready;
   assign w_r_hs  = axi_lite_req_o.r_ready  && axi_lite_rsp_i.r_valid;

   // AW and W complete independently; a channel is done once it has handshaken
   assign w_aw_done = r_aw_sent || w_aw_hs;
   assign w_w_done  = r_w_sent  || w_w_hs;

   // Next-state selection for the single-outstanding transaction sequencer
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_q_hs) begin
               if ((core_data_req_i.q.amo != AMONone) || !w_addr_hit) w_state_nxt = ERR_RESP;
               else if (core_data_req_i.q.write)                     w_state_nxt = WRITE;
               else                                                  w_state_nxt = READ;
            end
         end
         WRITE:    if (w_aw_done && w_w_done)         w_state_nxt = WRITE_B;
         WRITE_B:  if (w_b_hs)                        w_state_nxt = RESP;
         READ:     if (w_ar_hs)                       w_state_nxt = READ_R;
         READ_R:   if (w_r_hs)                        w_state_nxt = RESP;
         ERR_RESP:                                    w_state_nxt = RESP;
         RESP:     if (core_data_req_i.p_ready)       w_state_nxt = IDLE;
         default:                                     w_state_nxt = IDLE;
      endcase
   end

   // State, request capture, channel-sent tracking and response latching
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_live    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_pdata   <= '0;
         r_err     <= 1'b0;
         r_aw_sent <= 1'b0;
         r_w_sent  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (w_q_hs) begin
                  r_addr    <= core_data_req_i.q.addr;
                  r_wdata   <= core_data_req_i.q.data;
                  r_strb    <= core_data_req_i.q.strb;
                  r_aw_sent <= 1'b0;
                  r_w_sent  <= 1'b0;
               end
            end
            WRITE: begin
               if (w_aw_hs) r_aw_sent <= 1'b1;
               if (w_w_hs)  r_w_sent  <= 1'b1;
            end
            WRITE_B: begin
               if (w_b_hs) begin
                  r_err   <= axi_lite_rsp_i.b.resp[1];
                  r_pdata <= '0;
               end
            end
            READ_R: begin
               if (w_r_hs) begin
                  r_err   <= axi_lite_rsp_i.r.resp[1];
                  r_pdata <= axi_lite_rsp_i.r.data;
               end
            end
            ERR_RESP: begin
               r_err   <= 1'b1;
               r_pdata <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wl_reqrsp_axi_lite_bridge.sv
// Directed bench for the LSU-to-AXI-Lite bridge: inputs change on the falling
// edge, outputs are checked on the falling edge after the rising edge acts.
module tb_wl_reqrsp_axi_lite_bridge;
   import wl_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   core_data_req_t req;
   core_data_rsp_t rsp;
   axi_lite_req_t  axreq;
   axi_lite_resp_t axrsp;

   int n_vec = 0;
   int n_err = 0;
   int n_aw  = 0;
   int n_w   = 0;
   int n_vld = 0;
   int aw0, w0, v0;

   always #5 clk = ~clk;

   wl_reqrsp_axi_lite_bridge dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .core_data_req_i (req),
      .core_data_rsp_o (rsp),
      .axi_lite_req_o  (axreq),
      .axi_lite_rsp_i  (axrsp)
   );

   // Handshake and request-valid counters seen by the fabric side
   always @(posedge clk) begin
      if (axreq.aw_valid && axrsp.aw_ready) n_aw++;
      if (axreq.w_valid && axrsp.w_ready) n_w++;
      if (axreq.aw_valid || axreq.w_valid || axreq.ar_valid) n_vld++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic send_q(input logic [31:0] a, input logic wr, input amo_op_e amo,
                         input logic [31:0] d, input logic [3:0] s);
      req.q.addr  = a;
      req.q.write = wr;
      req.q.amo   = amo;
      req.q.data  = d;
      req.q.strb  = s;
      req.q.size  = 2'd2;
      req.q_valid = 1'b1;
   endtask

   // Single read against a slave that is ready at once and answers r one cycle later
   task automatic fwd_read(input string tag, input logic [31:0] a, input logic [31:0] d);
      axrsp.ar_ready = 1'b1;
      send_q(a, 1'b0, AMONone, 32'h0, 4'h0);
      step; req.q_valid = 1'b0;
      chk({tag, "_arv"}, axreq.ar_valid, 1);
      chk({tag, "_araddr"}, axreq.ar.addr, a);
      step; axrsp.ar_ready = 1'b0;
      axrsp.r_valid = 1'b1; axrsp.r.data = d; axrsp.r.resp = 2'b00;
      step; axrsp.r_valid = 1'b0;
      chk({tag, "_pvld"}, rsp.p_valid, 1);
      chk({tag, "_pdata"}, rsp.p.data, d);
      chk({tag, "_err"}, rsp.p.error, 0);
      req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;
   endtask

   initial begin
      req   = '0;
      axrsp = '0;
      rst   = 1'b1;

      // ---- reset state ----
      repeat (3) step;
      chk("rst_qrdy", rsp.q_ready, 0);
      chk("rst_pvld", rsp.p_valid, 0);
      chk("rst_axvld", {axreq.aw_valid, axreq.w_valid, axreq.ar_valid, axreq.b_ready, axreq.r_ready}, 0);
      chk("rst_pdata", rsp.p.data, 0);
      chk("rst_err", rsp.p.error, 0);
      rst = 1'b0;
      step;
      chk("post_rst_qrdy", rsp.q_ready, 1);

      // ---- write, always-ready slave, OKAY ----
      axrsp.aw_ready = 1'b1; axrsp.w_ready = 1'b1;
      axrsp.b_valid = 1'b1; axrsp.b.resp = 2'b00;
      send_q(32'h0002_0004, 1'b1, AMONone, 32'hDEAD_BEEF, 4'hF);
      step; req.q_valid = 1'b0;
      chk("wr_awv", axreq.aw_valid, 1);
      chk("wr_wv", axreq.w_valid, 1);
      chk("wr_awaddr", axreq.aw.addr, 32'h0002_0004);
      chk("wr_wdata", axreq.w.data, 32'hDEAD_BEEF);
      chk("wr_wstrb", axreq.w.strb, 4'hF);
      chk("wr_prot", axreq.aw.prot, 0);
      chk("wr_qrdy", rsp.q_ready, 0);
      step;
      chk("wr_bready", axreq.b_ready, 1);
      chk("wr_awv_drop", {axreq.aw_valid, axreq.w_valid}, 0);
      step;
      chk("wr_pvld", rsp.p_valid, 1);
      chk("wr_err", rsp.p.error, 0);
      chk("wr_pdata", rsp.p.data, 0);
      axrsp = '0; req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;
      chk("wr_turn_qrdy", rsp.q_ready, 1);
      chk("wr_pvld_off", rsp.p_valid, 0);

      // ---- AMO refused locally ----
      v0 = n_vld;
      send_q(32'h0002_0000, 1'b0, AMOAdd, 32'h1, 4'hF);
      step; req.q_valid = 1'b0;
      chk("amo_pvld_c1", rsp.p_valid, 0);
      chk("amo_arv", axreq.ar_valid, 0);
      step;
      chk("amo_pvld", rsp.p_valid, 1);
      chk("amo_err", rsp.p.error, 1);
      chk("amo_pdata", rsp.p.data, 0);
      chk("amo_no_axi", n_vld - v0, 0);
      req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;

      // ---- read with 5 r stall cycles, then 10 p_ready stall cycles ----
      axrsp.ar_ready = 1'b1;
      send_q(32'h0004_0000, 1'b0, AMONone, 32'h0, 4'h0);
      step; req.q_valid = 1'b0;
      chk("rd_arv", axreq.ar_valid, 1);
      chk("rd_araddr", axreq.ar.addr, 32'h0004_0000);
      step; axrsp.ar_ready = 1'b0;
      chk("rd_arv_drop", axreq.ar_valid, 0);
      chk("rd_rready", axreq.r_ready, 1);
      for (int i = 0; i < 5; i++) begin
         chk("rd_stall_qrdy", rsp.q_ready, 0);
         chk("rd_stall_pvld", rsp.p_valid, 0);
         step;
      end
      axrsp.r_valid = 1'b1; axrsp.r.data = 32'h0000_00A5; axrsp.r.resp = 2'b00;
      step; axrsp.r_valid = 1'b0;
      chk("rd_pvld", rsp.p_valid, 1);
      chk("rd_pdata", rsp.p.data, 32'h0000_00A5);
      chk("rd_err", rsp.p.error, 0);
      aw0 = n_aw;
      send_q(32'h0002_0000, 1'b1, AMONone, 32'h5555_5555, 4'hF);
      axrsp.aw_ready = 1'b1; axrsp.w_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step;
         chk("hold_pvld", rsp.p_valid, 1);
         chk("hold_pdata", rsp.p.data, 32'h0000_00A5);
         chk("hold_err", rsp.p.error, 0);
         chk("hold_qrdy", rsp.q_ready, 0);
      end
      chk("hold_no_aw", n_aw - aw0, 0);
      req.q_valid = 1'b0; axrsp = '0; req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;
      chk("hold_rel_pvld", rsp.p_valid, 0);
      chk("hold_rel_qrdy", rsp.q_ready, 1);

      // ---- write with W accepted 3 cycles before AW, SLVERR ----
      aw0 = n_aw; w0 = n_w;
      send_q(32'h0002_0008, 1'b1, AMONone, 32'h1234_5678, 4'h3);
      step; req.q_valid = 1'b0;
      chk("sk_awv", axreq.aw_valid, 1);
      chk("sk_wv", axreq.w_valid, 1);
      chk("sk_wstrb", axreq.w.strb, 4'h3);
      axrsp.w_ready = 1'b1;
      step; axrsp.w_ready = 1'b0;
      chk("sk_wv_drop", axreq.w_valid, 0);
      chk("sk_awv_hold", axreq.aw_valid, 1);
      step;
      chk("sk_awv_hold", axreq.aw_valid, 1);
      chk("sk_bready_early", axreq.b_ready, 0);
      step;
      chk("sk_awv_hold", axreq.aw_valid, 1);
      axrsp.aw_ready = 1'b1;
      step; axrsp.aw_ready = 1'b0;
      chk("sk_awv_drop", axreq.aw_valid, 0);
      chk("sk_bready", axreq.b_ready, 1);
      axrsp.b_valid = 1'b1; axrsp.b.resp = 2'b10;
      step; axrsp.b_valid = 1'b0; axrsp.b.resp = 2'b00;
      chk("sk_pvld", rsp.p_valid, 1);
      chk("sk_err", rsp.p.error, 1);
      chk("sk_pdata", rsp.p.data, 0);
      chk("sk_aw_once", n_aw - aw0, 1);
      chk("sk_w_once", n_w - w0, 1);
      req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;
      chk("sk_qrdy", rsp.q_ready, 1);

      // ---- reset pulsed while waiting for r ----
      axrsp.ar_ready = 1'b1;
      send_q(32'h0002_0010, 1'b0, AMONone, 32'h0, 4'h0);
      step; req.q_valid = 1'b0;
      step; axrsp.ar_ready = 1'b0;
      chk("rr_rready", axreq.r_ready, 1);
      rst = 1'b1;
      step; rst = 1'b0;
      chk("rr_rready_off", axreq.r_ready, 0);
      chk("rr_axv", {axreq.aw_valid, axreq.w_valid, axreq.ar_valid, axreq.b_ready}, 0);
      chk("rr_pvld", rsp.p_valid, 0);
      chk("rr_qrdy_rst", rsp.q_ready, 0);
      step;
      chk("rr_qrdy", rsp.q_ready, 1);

      // ---- address outside the memory map ----
`ifdef WL_BRIDGE_ADDR_CHECK_EN
      v0 = n_vld;
      send_q(32'h0003_0000, 1'b0, AMONone, 32'h0, 4'h0);
      step; req.q_valid = 1'b0;
      chk("ac_miss_arv", axreq.ar_valid, 0);
      step;
      chk("ac_miss_pvld", rsp.p_valid, 1);
      chk("ac_miss_err", rsp.p.error, 1);
      chk("ac_miss_no_axi", n_vld - v0, 0);
      req.p_ready = 1'b1;
      step; req.p_ready = 1'b0;
`else
      fwd_read("fw_hole", 32'h0003_0000, 32'h0000_005A);
`endif
      fwd_read("fw_imem", 32'h0001_0000, 32'hCAFE_0077);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
